// File: rtl/adc_sim_pkg.sv
// Shared types and constants for the ADC stimulus generator.
package adc_sim_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP       = 2'd0,
        MODE_CONST      = 2'd1,
        MODE_NOISE      = 2'd2,
        MODE_RAMP_NOISE = 2'd3
    } adc_mode_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/adc_lfsr16.sv
// 16-bit Galois LFSR (right shift) that advances on a strobe; exposes the low
// OUT_W bits of the state it is about to load.
module adc_lfsr16
    import adc_sim_pkg::*;
#(
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [OUT_W-1:0] noise_c
);

    logic [15:0] state;
    logic [15:0] state_nxt_c;

    always_comb begin
        state_nxt_c = {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        noise_c     = state_nxt_c[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (adv) begin
            state <= state_nxt_c;
        end
    end

endmodule

// File: rtl/adc_stim_gen.sv
// Periodic multi-channel ADC stimulus source: one valid pulse per period carrying
// a ramp, constant, LFSR-noise or ramp+noise sample from round-robin channels.
module adc_stim_gen
    import adc_sim_pkg::*;
#(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned PERIOD_CYC = 2000,
    parameter int unsigned VALID_CYC  = 2,
    parameter int unsigned NOISE_BITS = 4,
    parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] step,
    input  logic [DATA_W-1:0] const_value,
    output logic              response_valid_out,
    output logic [DATA_W-1:0] ADC_out,
    output logic [CH_W-1:0]   channel_out,
    output logic [31:0]       sample_count_out
);

    localparam int unsigned       PCNT_W     = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned       RAMP_N     = 2 ** CH_W;
    localparam logic [PCNT_W-1:0] LAUNCH_AT  = PCNT_W'(PERIOD_CYC - VALID_CYC - 1);
    localparam logic [PCNT_W-1:0] LAST_PCNT  = PCNT_W'(PERIOD_CYC - 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [DATA_W-1:0] NOISE_MASK = DATA_W'((64'd1 << NOISE_BITS) - 64'd1);

    if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
        $error("adc_stim_gen: DATA_W must be 1..16");
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("adc_stim_gen: NUM_CH must be >= 1");
    end
    if (VALID_CYC < 1 || VALID_CYC >= PERIOD_CYC) begin : g_bad_valid
        $error("adc_stim_gen: need 1 <= VALID_CYC < PERIOD_CYC");
    end
    if (NOISE_BITS >= DATA_W) begin : g_bad_noise
        $error("adc_stim_gen: NOISE_BITS must be < DATA_W");
    end

    logic [PCNT_W-1:0] pcnt;
    logic [CH_W-1:0]   next_ch;
    logic [DATA_W-1:0] ramp [RAMP_N];

    logic              advance_c;
    logic              launch_c;
    logic              wrap_c;
    logic              ramp_we_c;
    adc_mode_t         mode_c;
    logic [DATA_W-1:0] ramp_sum_c;
    logic [DATA_W-1:0] noise_c;
    logic [DATA_W-1:0] adc_nxt_c;

    adc_lfsr16 #(
        .OUT_W (DATA_W)
    ) u_lfsr (
        .clk     (MAX10_CLK1_50),
        .rst_n   (reset_n),
        .adv     (launch_c),
        .noise_c (noise_c)
    );

    // An idle counter waits at zero for enable; once started a period always completes.
    always_comb begin
        advance_c  = (pcnt != '0) || enable;
        launch_c   = advance_c && (pcnt == LAUNCH_AT);
        wrap_c     = advance_c && (pcnt == LAST_PCNT);
        mode_c     = adc_mode_t'(mode);
        ramp_sum_c = ramp[next_ch] + step;
        ramp_we_c  = 1'b0;
        adc_nxt_c  = ramp_sum_c;
        case (mode_c)
            MODE_RAMP: begin
                ramp_we_c = 1'b1;
                adc_nxt_c = ramp_sum_c;
            end
            MODE_CONST:  adc_nxt_c = const_value;
            MODE_NOISE:  adc_nxt_c = noise_c;
            MODE_RAMP_NOISE: begin
                ramp_we_c = 1'b1;
                adc_nxt_c = (ramp_sum_c & ~NOISE_MASK) | (noise_c & NOISE_MASK);
            end
            default: adc_nxt_c = ramp_sum_c;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            pcnt               <= '0;
            response_valid_out <= 1'b0;
            ADC_out            <= '0;
            channel_out        <= '0;
            next_ch            <= '0;
            sample_count_out   <= '0;
            for (int i = 0; i < RAMP_N; i++) begin
                ramp[i] <= '0;
            end
        end else begin
            if (advance_c) begin
                pcnt <= wrap_c ? '0 : pcnt + PCNT_W'(1);
            end
            if (launch_c) begin
                response_valid_out <= 1'b1;
                ADC_out            <= adc_nxt_c;
                channel_out        <= next_ch;
                next_ch            <= (next_ch == LAST_CH) ? '0 : next_ch + CH_W'(1);
                sample_count_out   <= sample_count_out + 32'd1;
                if (ramp_we_c) begin
                    ramp[next_ch] <= ramp_sum_c;
                end
            end else if (wrap_c) begin
                response_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_stim_gen.sv
// Bench for adc_stim_gen: hand sequences on a default instance, a vector table
// and a randomized run against a behavioural model on a 3-channel instance, and
// a ramp-wrap check on a 4-bit instance.
module tb_adc_stim_gen;

    localparam int P1 = 16;
    localparam int V1 = 3;
    localparam int N1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance 0: default parameters
    logic        rst0, en0, v0;
    logic [1:0]  mode0;
    logic [11:0] step0, cv0, adc0;
    logic [0:0]  ch0;
    logic [31:0] cnt0;

    // Instance 1: 3 channels, short period
    logic        rst1, en1, v1;
    logic [1:0]  mode1;
    logic [11:0] step1, cv1, adc1;
    logic [1:0]  ch1;
    logic [31:0] cnt1;

    // Instance 2: 4-bit data
    logic        rst2, en2, v2;
    logic [1:0]  mode2;
    logic [3:0]  step2, cv2, adc2;
    logic [0:0]  ch2;
    logic [31:0] cnt2;

    adc_stim_gen u_d0 (
        .MAX10_CLK1_50(clk), .reset_n(rst0), .enable(en0), .mode(mode0),
        .step(step0), .const_value(cv0), .response_valid_out(v0),
        .ADC_out(adc0), .channel_out(ch0), .sample_count_out(cnt0)
    );

    adc_stim_gen #(.DATA_W(12), .NUM_CH(N1), .PERIOD_CYC(P1), .VALID_CYC(V1), .NOISE_BITS(4)) u_d1 (
        .MAX10_CLK1_50(clk), .reset_n(rst1), .enable(en1), .mode(mode1),
        .step(step1), .const_value(cv1), .response_valid_out(v1),
        .ADC_out(adc1), .channel_out(ch1), .sample_count_out(cnt1)
    );

    adc_stim_gen #(.DATA_W(4), .NUM_CH(1), .PERIOD_CYC(8), .VALID_CYC(1), .NOISE_BITS(2)) u_d2 (
        .MAX10_CLK1_50(clk), .reset_n(rst2), .enable(en2), .mode(mode2),
        .step(step2), .const_value(cv2), .response_valid_out(v2),
        .ADC_out(adc2), .channel_out(ch2), .sample_count_out(cnt2)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] step;
        logic [11:0] cv;
        logic [11:0] exp_adc;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t tbl [8];

    // Behavioural reference for instance 1
    int          m_pcnt, m_next, m_ch;
    int          m_ramp [N1];
    logic [11:0] m_adc;
    logic [15:0] m_lfsr;
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset();
        m_pcnt = 0;
        m_next = 0;
        m_ch   = 0;
        m_adc  = '0;
        m_lfsr = 16'hACE1;
        m_cnt  = '0;
        for (int i = 0; i < N1; i++) m_ramp[i] = 0;
    endtask

    task automatic model_edge(input bit en, input int md, input int st, input int cv);
        bit adv;
        int c;
        adv = (m_pcnt != 0) || en;
        if (adv && m_pcnt == P1 - V1 - 1) begin
            m_lfsr = lfsr_step(m_lfsr);
            c      = m_next;
            m_ch   = c;
            m_next = (m_next + 1) % N1;
            m_cnt  = m_cnt + 32'd1;
            if (md == 0 || md == 3) m_ramp[c] = (m_ramp[c] + st) % 4096;
            case (md)
                0:       m_adc = 12'(m_ramp[c]);
                1:       m_adc = 12'(cv);
                2:       m_adc = m_lfsr[11:0];
                default: m_adc = 12'((m_ramp[c] / 16) * 16 + int'(m_lfsr[3:0]));
            endcase
        end
        if (adv) m_pcnt = (m_pcnt + 1) % P1;
    endtask

    task automatic d0_reset();
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        rst0 = 1'b1;
    endtask

    task automatic d0_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_v(input int which, input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((which == 1 ? v1 : v2) === lvl) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hits;
        int exp2 [4];

        tbl[0] = '{2'd0, 12'd4,     12'h000, 12'd4,     2'd0};
        tbl[1] = '{2'd0, 12'd4,     12'h000, 12'd4,     2'd1};
        tbl[2] = '{2'd0, 12'd4,     12'h000, 12'd4,     2'd2};
        tbl[3] = '{2'd0, 12'd4,     12'h000, 12'd8,     2'd0};
        tbl[4] = '{2'd1, 12'd4,     12'h123, 12'h123,   2'd1};
        tbl[5] = '{2'd0, 12'hFFF,   12'h000, 12'd3,     2'd2};
        tbl[6] = '{2'd0, 12'd1,     12'h000, 12'd9,     2'd0};
        tbl[7] = '{2'd0, 12'd1,     12'h000, 12'd5,     2'd1};
        exp2   = '{5, 10, 15, 4};

        rst0 = 1'b0; en0 = 1'b1; mode0 = 2'd0; step0 = 12'd1; cv0 = '0;
        rst1 = 1'b0; en1 = 1'b1; mode1 = 2'd0; step1 = 12'd4; cv1 = '0;
        rst2 = 1'b0; en2 = 1'b1; mode2 = 2'd0; step2 = 4'd5;  cv2 = '0;

        // Reset state of the default instance
        @(negedge clk);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_adc",   32'(adc0), 32'd0);
        chk("rst_cnt",   cnt0, 32'd0);

        // Ramp from reset: first launch on edge 1998, pulse 2 cycles wide
        d0_reset();
        d0_edges(1997); chk("t1_pre_valid", 32'(v0), 32'd0);
        d0_edges(1);    chk("t1_valid", 32'(v0), 32'd1);
        chk("t1_adc", 32'(adc0), 32'd1);
        chk("t1_ch",  32'(ch0), 32'd0);
        chk("t1_cnt", cnt0, 32'd1);
        d0_edges(1);    chk("t1_valid2", 32'(v0), 32'd1);
        d0_edges(1);    chk("t1_fall", 32'(v0), 32'd0);
        chk("t1_hold_adc", 32'(adc0), 32'd1);
        d0_edges(1997); chk("t1_pre_valid_b", 32'(v0), 32'd0);
        d0_edges(1);    chk("t1_valid_b", 32'(v0), 32'd1);
        chk("t1_adc_b", 32'(adc0), 32'd2);
        chk("t1_cnt_b", cnt0, 32'd2);

        // Enable dropped mid-period: pulse completes, then counter idles
        d0_reset();
        d0_edges(1000); en0 = 1'b0;
        d0_edges(998);  chk("t4_valid", 32'(v0), 32'd1);
        d0_edges(2);    chk("t4_fall", 32'(v0), 32'd0);
        hits = 0;
        for (int i = 0; i < 3000; i++) begin
            d0_edges(1);
            if (v0 !== 1'b0) hits++;
        end
        chk("t4_idle_pulses", 32'(hits), 32'd0);
        chk("t4_idle_cnt", cnt0, 32'd1);
        en0 = 1'b1;
        d0_edges(1997); chk("t4_pre_relaunch", 32'(v0), 32'd0);
        d0_edges(1);    chk("t4_relaunch", 32'(v0), 32'd1);
        chk("t4_adc", 32'(adc0), 32'd2);
        chk("t4_cnt", cnt0, 32'd2);

        // Constant mode, and inputs only take effect at a launch
        mode0 = 2'd1; cv0 = 12'hABC;
        d0_reset();
        d0_edges(1998); chk("t5_const", 32'(adc0), 32'hABC);
        mode0 = 2'd0; step0 = 12'd1;
        d0_edges(1);    chk("t5_const_hold", 32'(adc0), 32'hABC);
        d0_edges(1999); chk("t5_ramp_after", 32'(adc0), 32'd1);
        chk("t5_cnt", cnt0, 32'd2);
        d0_edges(1000); mode0 = 2'd1; cv0 = 12'h555;
        d0_edges(500);  chk("t5_midperiod_hold", 32'(adc0), 32'd1);
        d0_edges(500);  chk("t5_const_next", 32'(adc0), 32'h555);
        chk("t5_valid", 32'(v0), 32'd1);

        // Noise mode from reset
        mode0 = 2'd2;
        d0_reset();
        d0_edges(1998); chk("t5_noise1", 32'(adc0), 32'h270);
        d0_edges(2000); chk("t5_noise2", 32'(adc0), 32'h138);

        // Reset asserted in the middle of a pulse
        mode0 = 2'd0; step0 = 12'd1;
        d0_reset();
        d0_edges(1998); chk("t6_valid_before", 32'(v0), 32'd1);
        #2 rst0 = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(v0), 32'd0);
        chk("t6_rst_adc",   32'(adc0), 32'd0);
        chk("t6_rst_cnt",   cnt0, 32'd0);
        @(negedge clk); rst0 = 1'b1;
        d0_edges(1998); chk("t6_first", 32'(adc0), 32'd1);
        chk("t6_cnt", cnt0, 32'd1);

        // Table-driven: 3-channel round robin
        mode1 = tbl[0].mode; step1 = tbl[0].step; cv1 = tbl[0].cv;
        @(negedge clk); rst1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mode1 = tbl[i].mode; step1 = tbl[i].step; cv1 = tbl[i].cv;
            wait_v(1, 1'b1, ok);
            chk($sformatf("tbl%0d_rise", i), 32'(ok), 32'd1);
            chk($sformatf("tbl%0d_adc", i), 32'(adc1), 32'(tbl[i].exp_adc));
            chk($sformatf("tbl%0d_ch", i),  32'(ch1),  32'(tbl[i].exp_ch));
            chk($sformatf("tbl%0d_cnt", i), cnt1, 32'(i + 1));
            wait_v(1, 1'b0, ok);
            chk($sformatf("tbl%0d_fall", i), 32'(ok), 32'd1);
        end

        // 4-bit ramp wrap
        @(negedge clk); rst2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_v(2, 1'b1, ok);
            chk($sformatf("w4_rise%0d", i), 32'(ok), 32'd1);
            chk($sformatf("w4_adc%0d", i), 32'(adc2), 32'(exp2[i]));
            wait_v(2, 1'b0, ok);
        end

        // Randomized run of instance 1 against the reference model
        @(negedge clk); rst1 = 1'b0;
        @(negedge clk); rst1 = 1'b1;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            chk("rnd_valid", 32'(v1), 32'(m_pcnt >= P1 - V1));
            chk("rnd_adc",   32'(adc1), 32'(m_adc));
            chk("rnd_ch",    32'(ch1), 32'(m_ch));
            chk("rnd_cnt",   cnt1, m_cnt);
            en1   = ($urandom_range(0, 9) != 0);
            mode1 = 2'($urandom_range(0, 3));
            step1 = 12'($urandom);
            cv1   = 12'($urandom);
            model_edge(en1, int'(mode1), int'(step1), int'(cv1));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
